// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the program counter through the
// IDLE/LOAD/RUN/HALTED sequence, resolves taken branches through a small
// register-file target LUT and counts retired instructions.
module fetch_ctrl #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned LUT_DEPTH  = 8,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         start,
  input  logic                         HALT_REQ,
  input  logic                         BRANCH,
  input  logic                         ZERO,
  input  logic [$clog2(LUT_DEPTH)-1:0] TGT_SEL,
  input  logic                         LUT_WE,
  input  logic [$clog2(LUT_DEPTH)-1:0] LUT_ADDR,
  input  logic [PC_W-1:0]              LUT_DATA,
  output logic [PC_W-1:0]              PC,
  output logic                         halt,
  output logic                         running,
  output logic [CNT_W-1:0]             InstCounter
);

  localparam logic [PC_W-1:0] StartPc = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] PcMax   = '1;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StHalted} state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_q, halt_d;
  logic             running_q, running_d;
  logic [PC_W-1:0]  lut_q [LUT_DEPTH];

  // Next-state, next-PC and retire-count decode; start overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = StLoad;
      pc_d    = StartPc;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StIdle;
        StLoad:   state_d = StRun;
        StRun: begin
          // Every RUN edge retires one instruction, including the one that halts.
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          if (HALT_REQ) begin
            state_d = StHalted;
          end else if (BRANCH && ZERO) begin
            // Registered LUT read: a same-edge write is seen only afterwards.
            pc_d = lut_q[TGT_SEL];
          end else if (pc_q == PcMax) begin
            state_d = StHalted;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
        StHalted: state_d = StHalted;
        default:  state_d = StIdle;
      endcase
    end
    running_d = (state_d == StRun);
    halt_d    = (state_d == StHalted);
  end

  // State, registered outputs and LUT storage; reset clears everything at once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StIdle;
      pc_q      <= StartPc;
      cnt_q     <= '0;
      halt_q    <= 1'b0;
      running_q <= 1'b0;
      for (int i = 0; i < int'(LUT_DEPTH); i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      halt_q    <= halt_d;
      running_q <= running_d;
      if (LUT_WE) begin
        lut_q[LUT_ADDR] <= LUT_DATA;
      end
    end
  end

  assign PC          = pc_q;
  assign halt        = halt_q;
  assign running     = running_q;
  assign InstCounter = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a behavioural model pushes the expected
// post-edge outputs for each driven cycle, which are popped and compared.
module tb_fetch_ctrl;

  localparam int MIdle = 0, MLoad = 1, MRun = 2, MHalt = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, halt_req, branch, zero, lut_we;
  logic [2:0] tgt_sel, lut_addr;
  logic [9:0] lut_data;
  logic [9:0] pc;
  logic       halt, running;
  logic [15:0] cnt;
  logic [9:0] pc_s;
  logic       halt_s, running_s;
  logic [2:0] cnt_s;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .CLK(clk), .RESET(rst_n), .start(start), .HALT_REQ(halt_req), .BRANCH(branch),
    .ZERO(zero), .TGT_SEL(tgt_sel), .LUT_WE(lut_we), .LUT_ADDR(lut_addr),
    .LUT_DATA(lut_data), .PC(pc), .halt(halt), .running(running), .InstCounter(cnt)
  );

  // Narrow-counter copy, used only to observe saturation.
  fetch_ctrl #(.CNT_W(3)) dut_sat (
    .CLK(clk), .RESET(rst_n), .start(start), .HALT_REQ(halt_req), .BRANCH(branch),
    .ZERO(zero), .TGT_SEL(tgt_sel), .LUT_WE(lut_we), .LUT_ADDR(lut_addr),
    .LUT_DATA(lut_data), .PC(pc_s), .halt(halt_s), .running(running_s),
    .InstCounter(cnt_s)
  );

  typedef struct packed {
    logic [9:0]  pc;
    logic [15:0] cnt;
    logic        run;
    logic        hlt;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_bad = 0;
  int         m_state;
  logic [9:0] m_pc;
  logic [15:0] m_cnt;
  logic [9:0] m_lut [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = MIdle;
    m_pc    = 10'h000;
    m_cnt   = 16'h0000;
    for (int i = 0; i < 8; i++) m_lut[i] = 10'h000;
  endtask

  task automatic drv(input logic s, input logic hr, input logic br, input logic z,
                     input logic [2:0] tg, input logic we, input logic [2:0] wa,
                     input logic [9:0] wd);
    start = s; halt_req = hr; branch = br; zero = z; tgt_sel = tg;
    lut_we = we; lut_addr = wa; lut_data = wd;
  endtask

  // Model one edge from the current inputs, push expectation, then compare.
  task automatic cycle(input string tag);
    exp_t e;
    int ns;
    logic [9:0] npc;
    logic [15:0] ncnt;
    ns = m_state; npc = m_pc; ncnt = m_cnt;
    if (start) begin
      ns = MLoad; npc = 10'h000; ncnt = 16'h0000;
    end else if (m_state == MLoad) begin
      ns = MRun;
    end else if (m_state == MRun) begin
      if (m_cnt != 16'hFFFF) ncnt = m_cnt + 16'd1;
      if (halt_req) ns = MHalt;
      else if (branch && zero) npc = m_lut[tgt_sel];
      else if (m_pc == 10'h3FF) ns = MHalt;
      else npc = m_pc + 10'd1;
    end
    if (lut_we) m_lut[lut_addr] = lut_data;
    m_state = ns; m_pc = npc; m_cnt = ncnt;
    e.pc = npc; e.cnt = ncnt; e.run = (ns == MRun); e.hlt = (ns == MHalt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ":sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ":pc"}, 32'(pc), 32'(e.pc));
      check({tag, ":cnt"}, 32'(cnt), 32'(e.cnt));
      check({tag, ":running"}, 32'(running), 32'(e.run));
      check({tag, ":halt"}, 32'(halt), 32'(e.hlt));
      check({tag, ":excl"}, 32'(running & halt), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 3'd0, 0, 3'd0, 10'h000);
    model_reset();
    #1;
    check("rst_pc", 32'(pc), 32'h000);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle must not start without start.
    for (int i = 0; i < 3; i++) cycle("idle");

    // Basic sequencing: two LOAD edges, RUN entry, five retires.
    drv(1, 0, 0, 0, 3'd0, 0, 3'd0, 10'h000);
    cycle("load0");
    cycle("load1");
    drv(0, 0, 0, 0, 3'd0, 0, 3'd0, 10'h000);
    cycle("enter");
    for (int i = 0; i < 5; i++) cycle("seq");
    check("seq_pc5", 32'(pc), 32'h005);
    check("seq_cnt5", 32'(cnt), 32'd5);
    check("seq_running", 32'(running), 32'd1);
    check("sat_cnt5", 32'(cnt_s), 32'd5);
    for (int i = 0; i < 4; i++) cycle("seq2");
    check("sat_cnt7", 32'(cnt_s), 32'd7);
    check("nosat_cnt9", 32'(cnt), 32'd9);

    // Load branch targets while running.
    drv(0, 0, 0, 0, 3'd0, 1, 3'd3, 10'h040); cycle("wr3");
    drv(0, 0, 0, 0, 3'd0, 1, 3'd1, 10'h010); cycle("wr1");
    drv(0, 0, 0, 0, 3'd0, 1, 3'd4, 10'h020); cycle("wr4");

    drv(0, 0, 1, 1, 3'd1, 0, 3'd0, 10'h000); cycle("br_010");
    drv(0, 0, 1, 1, 3'd3, 0, 3'd0, 10'h000); cycle("br_040");
    check("br_taken_040", 32'(pc), 32'h040);
    drv(0, 0, 1, 1, 3'd1, 0, 3'd0, 10'h000); cycle("br_010b");
    drv(0, 0, 1, 0, 3'd3, 0, 3'd0, 10'h000); cycle("br_nz");
    check("br_not_taken_011", 32'(pc), 32'h011);

    // Halt wins over a taken branch.
    drv(0, 0, 1, 1, 3'd4, 0, 3'd0, 10'h000); cycle("br_020");
    drv(0, 1, 1, 1, 3'd3, 0, 3'd0, 10'h000); cycle("halt_req");
    check("halt_pc", 32'(pc), 32'h020);
    check("halt_flag", 32'(halt), 32'd1);
    check("halt_cnt", 32'(cnt), 32'd18);
    for (int i = 0; i < 3; i++) begin
      drv(0, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 0, 3'd0, 10'h000);
      cycle("frozen");
    end
    check("frozen_cnt", 32'(cnt), 32'd18);
    check("frozen_pc", 32'(pc), 32'h020);

    // End-of-memory halt without wrap.
    drv(1, 0, 0, 0, 3'd0, 0, 3'd0, 10'h000); cycle("reload");
    drv(0, 0, 0, 0, 3'd0, 0, 3'd0, 10'h000); cycle("enter2");
    drv(0, 0, 0, 0, 3'd0, 1, 3'd6, 10'h3FD); cycle("wr6");
    drv(0, 0, 1, 1, 3'd6, 0, 3'd0, 10'h000); cycle("br_3fd");
    drv(0, 0, 0, 0, 3'd0, 0, 3'd0, 10'h000);
    for (int i = 0; i < 4; i++) begin
      cycle("top");
      check("top_nowrap", 32'(pc == 10'h000), 32'd0);
    end
    check("top_pc", 32'(pc), 32'h3FF);
    check("top_halt", 32'(halt), 32'd1);
    drv(1, 0, 0, 0, 3'd0, 0, 3'd0, 10'h000); cycle("reload2");
    check("reload_pc", 32'(pc), 32'h000);
    check("reload_cnt", 32'(cnt), 32'd0);
    check("reload_running", 32'(running), 32'd0);

    // Same-edge write and lookup sees the old entry.
    drv(0, 0, 0, 0, 3'd0, 0, 3'd0, 10'h000); cycle("enter3");
    drv(0, 0, 0, 0, 3'd0, 1, 3'd2, 10'h080); cycle("wr2old");
    drv(0, 0, 1, 1, 3'd2, 1, 3'd2, 10'h100); cycle("br_same_edge");
    check("same_edge_old", 32'(pc), 32'h080);
    drv(0, 0, 1, 1, 3'd2, 0, 3'd0, 10'h000); cycle("br_new");
    check("same_edge_new", 32'(pc), 32'h100);

    // Random mix, including mid-run restarts and writes in every state.
    for (int i = 0; i < 60; i++) begin
      drv(($urandom_range(15) == 0), ($urandom_range(7) == 0), 1'($urandom), 1'($urandom),
          3'($urandom), ($urandom_range(3) == 0), 3'($urandom), 10'($urandom));
      cycle("rand");
    end

    // Asynchronous reset mid-run.
    drv(1, 0, 0, 0, 3'd0, 0, 3'd0, 10'h000); cycle("reload3");
    drv(0, 0, 0, 0, 3'd0, 0, 3'd0, 10'h000); cycle("enter4");
    drv(0, 0, 0, 0, 3'd0, 1, 3'd5, 10'h033); cycle("wr5");
    drv(0, 0, 1, 1, 3'd5, 0, 3'd0, 10'h000); cycle("br_033");
    check("pre_reset_pc", 32'(pc), 32'h033);
    drv(0, 0, 0, 0, 3'd0, 0, 3'd0, 10'h000);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_pc", 32'(pc), 32'h000);
    check("async_cnt", 32'(cnt), 32'd0);
    check("async_running", 32'(running), 32'd0);
    check("async_halt", 32'(halt), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_idle");
    check("post_idle_running", 32'(running), 32'd0);
    drv(1, 0, 0, 0, 3'd0, 0, 3'd0, 10'h000); cycle("post_load");
    drv(0, 0, 0, 0, 3'd0, 0, 3'd0, 10'h000); cycle("post_enter");
    cycle("post_step");
    drv(0, 0, 1, 1, 3'd5, 0, 3'd0, 10'h000); cycle("post_br");
    check("lut_cleared", 32'(pc), 32'h000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
